fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of the synchronous FIFO between NUM_REQ requesters.
- Each requester has a valid/ready handshake.
- The winner holds the port for a burst of up to MAX_BURST writes, or until it drops valid.
- Sits directly in front of the FIFO and drives its wr_en/data_in; it observes the FIFO's full flag.
- The read side of the FIFO is untouched.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 16, FIFO data width.
- MAX_BURST, 4, maximum writes per grant (1..15).
- ID_W, $clog2(NUM_REQ), grant index width (derived, not overridden).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_data  in  NUM_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- fifo_full  in  1  FIFO full flag.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_data_in  out  DATA_WIDTH  FIFO write data.
- grant_active  out  1  a grant is currently held.
- grant_id  out  ID_W  index of the current grantee.

Behaviour:
- Reset (async, rst=1) forces:
  - state=IDLE, grant_id=0, grant_active=0, rr_ptr=0, beat_cnt=0.
  - req_ready=0, fifo_wr_en=0, fifo_data_in=0.
- FSM has two states: IDLE, GRANT.
- IDLE:
  - If any req_valid is high, choose the first set bit scanning from rr_ptr upward, wrapping modulo NUM_REQ.
  - Register the winner into grant_id, clear beat_cnt, go to GRANT.
  - Nothing is accepted in IDLE, so arbitration latency is 1 cycle from valid to the first possible write.
- GRANT (outputs combinational from state/registers and current inputs; g = grant_id):
  - grant_active=1.
  - req_ready[g] = ~fifo_full; all other req_ready bits are 0.
  - fifo_wr_en = req_valid[g] & ~fifo_full.
  - fifo_data_in = req_data slice g when in GRANT, else 0.
  - A beat is a cycle with fifo_wr_en=1; beat_cnt increments on each beat.
- Release from GRANT to IDLE happens at the clock edge when either:
  - a beat occurs with beat_cnt==MAX_BURST-1, or
  - req_valid[g]==0 (no beat that cycle).
  - On release, rr_ptr = (g+1) mod NUM_REQ.
- fifo_full=1 while in GRANT:
  - No beat; beat_cnt and grant are held indefinitely.
  - The grantee keeps ownership until full clears. There is no timeout.
- Handover: there is always exactly one IDLE bubble cycle between grants, including a re-grant to the same requester.
- Fairness: a requester continuously asserting valid is granted at least once every NUM_REQ grants.
- Requesters may drop valid at any time. Data is only consumed on req_valid & req_ready.
- Reset mid-burst: the in-flight beat is not written, and the next grant starts from rr_ptr=0.
- Internal widths: beat_cnt is 4 bits. rr_ptr and grant_id are ID_W bits, with wrap computed explicitly for non-power-of-2 NUM_REQ.

Optional Feature:
FIFO_ARB_STATS_EN
- Defined:
  - Adds output stat_grants, NUM_REQ*16 bits.
  - Slice i counts beats written for requester i and saturates at 16'hFFFF.
  - Cleared by rst.
- Undefined: the port and its counters are absent. All other behaviour is identical.

Decomposition:
- Shared package holds:
  - typedef enum {IDLE, GRANT} arb_state_e.
  - localparam STAT_W=16.
- One sub-module, rr_pick: purely combinational. It takes req vector + rr_ptr and returns winner index + any_req. It is instantiated once.
- The FSM, counters and mux stay in fifo_wr_arbiter.

Test Plan:
- Single requester: req_valid=4'b0100, fifo_full=0, data 0xA0..0xA5 → grant_id=2 after 1 cycle; 4 writes 0xA0..0xA3; IDLE bubble; re-grant; 0xA4,0xA5.
- All requesting: req_valid=4'b1111, held 20 cycles → grant order 0,1,2,3,0. Each grant gives 4 beats then 1 bubble. fifo_wr_en pattern is 4 on / 1 off.
- Full stall: mid-burst of requester 1 after 2 beats, fifo_full=1 for 5 cycles → fifo_wr_en=0 and req_ready=0 for those 5 cycles, grant_id stays 1. After full drops, exactly 2 more beats, then release.
- Early drop: requester 3 granted, drops valid after 1 beat → release that cycle. rr_ptr=0, so the next grant goes to requester 0 if valid.
- Async reset: assert rst between clock edges during a burst → all outputs 0 immediately. After release, with req_valid=4'b1010, first grant goes to requester 1.
- With FIFO_ARB_STATS_EN: 3 beats from requester 0 and 4 from requester 2 → stat_grants slice0=3, slice2=4, others 0.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// rtl/fifo_wr_arbiter_pkg.sv - shared types and constants for the FIFO write-port arbiter
package fifo_wr_arbiter_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_e;

  localparam int STAT_W = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin winner search starting at ptr
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    winner,
  output logic               any_req
);

  always_comb begin
    int idx;
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // explicit wrap keeps non-power-of-2 NUM_REQ in range
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter driving a FIFO write port
// Optional per-requester beat counters on stat_grants when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 16,
  parameter  int MAX_BURST  = 4,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic                          grant_active,
`ifdef FIFO_ARB_STATS_EN
  output logic [NUM_REQ*STAT_W-1:0]     stat_grants,
`endif
  output logic [ID_W-1:0]               grant_id
);

  arb_state_e      state, state_nxt;
  logic [ID_W-1:0] rr_ptr, ptr_nxt, gid_nxt, pick_id;
  logic [3:0]      beat_cnt, beat_nxt;
  logic            any_req, rel;

  rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .winner  (pick_id),
    .any_req (any_req)
  );

  always_comb begin
    state_nxt    = state;
    gid_nxt      = grant_id;
    ptr_nxt      = rr_ptr;
    beat_nxt     = beat_cnt;
    rel          = 1'b0;
    grant_active = 1'b0;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_data_in = '0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = GRANT;
          gid_nxt   = pick_id;
          beat_nxt  = '0;
        end
      end
      GRANT: begin
        grant_active        = 1'b1;
        req_ready[grant_id] = ~fifo_full;
        fifo_wr_en          = req_valid[grant_id] & ~fifo_full;
        fifo_data_in        = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
        // a full FIFO neither counts a beat nor releases the grant
        if (fifo_wr_en) begin
          beat_nxt = beat_cnt + 4'd1;
          if (beat_cnt == 4'(MAX_BURST - 1)) rel = 1'b1;
        end else if (!req_valid[grant_id]) begin
          rel = 1'b1;
        end
        if (rel) begin
          state_nxt = IDLE;
          ptr_nxt   = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant_id <= gid_nxt;
      rr_ptr   <= ptr_nxt;
      beat_cnt <= beat_nxt;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_W-1:0] stat_cnt [NUM_REQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) stat_cnt[i] <= '0;
    end else if (fifo_wr_en && (stat_cnt[grant_id] != '1)) begin
      stat_cnt[grant_id] <= stat_cnt[grant_id] + STAT_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    assign stat_grants[i*STAT_W +: STAT_W] = stat_cnt[i];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter with a behavioural grant model
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            fifo_full = 1'b0;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_data_in;
  logic            grant_active;
  logic [1:0]      grant_id;
`ifdef FIFO_ARB_STATS_EN
  logic [N*16-1:0] stat_grants;
`endif

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .grant_active (grant_active),
`ifdef FIFO_ARB_STATS_EN
    .stat_grants  (stat_grants),
`endif
    .grant_id     (grant_id)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: owner -1 means nobody holds the port
  int            m_owner = -1;
  int            m_ptr   = 0;
  int            m_beats = 0;
  int            m_gid   = 0;
  int            m_stats [N];
  logic [DW-1:0] exp_q [$];

  always @(negedge clk) begin
    logic [N-1:0] e_ready;
    logic         e_wr;
    logic         found;
    e_ready = '0;
    e_wr    = 1'b0;
    found   = 1'b0;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_beats = 0; m_gid = 0;
      for (int i = 0; i < N; i++) m_stats[i] = 0;
      chk("reset_outputs", 64'({req_ready, fifo_wr_en, fifo_data_in, grant_active, grant_id}), 64'(0));
    end else begin
      if (m_owner >= 0) begin
        e_ready = fifo_full ? '0 : N'(1 << m_owner);
        e_wr    = req_valid[m_owner] && !fifo_full;
        if (e_wr) exp_q.push_back(req_data[m_owner*DW +: DW]);
        chk("grant_data", 64'(fifo_data_in), 64'(req_data[m_owner*DW +: DW]));
      end else begin
        chk("idle_data", 64'(fifo_data_in), 64'(0));
      end
      chk("grant_active", 64'(grant_active), 64'(m_owner >= 0));
      chk("grant_id", 64'(grant_id), 64'(m_gid));
      chk("req_ready", 64'(req_ready), 64'(e_ready));
      chk("fifo_wr_en", 64'(fifo_wr_en), 64'(e_wr));
      if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          if (!found && req_valid[(m_ptr + k) % N]) begin
            found   = 1'b1;
            m_owner = (m_ptr + k) % N;
          end
        end
        if (found) begin m_gid = m_owner; m_beats = 0; end
      end else if (e_wr) begin
        m_stats[m_owner]++;
        m_beats++;
        if (m_beats == MB) begin m_ptr = (m_owner + 1) % N; m_owner = -1; end
      end else if (!req_valid[m_owner]) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1;
      end
    end
  end

  // monitor: pops the scoreboard whenever the DUT writes
  int            w_cnt = 0;
  logic [DW-1:0] last_data = '0;

  always @(negedge clk) begin
    #1;
    if (!rst && fifo_wr_en) begin
      w_cnt++;
      last_data = fifo_data_in;
      if (exp_q.size() == 0) chk("unexpected_write", 64'(fifo_data_in), 64'hDEAD_0000_0000);
      else chk("write_data", 64'(fifo_data_in), 64'(exp_q.pop_front()));
    end
  end

  int base [N];
  int seq  [N];

  task automatic drive_data();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'(base[i] + seq[i]);
  endtask

  task automatic step();
    @(negedge clk);
    #2;
    for (int i = 0; i < N; i++) if (!rst && req_valid[i] && req_ready[i]) seq[i]++;
    @(posedge clk);
    #1;
    drive_data();
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; fifo_full = 1'b0;
    for (int i = 0; i < N; i++) seq[i] = 0;
    step();
    rst = 1'b0;
  endtask

  int w0;

  initial begin
    for (int i = 0; i < N; i++) begin base[i] = i << 12; seq[i] = 0; end
    drive_data();
    repeat (2) step();
    rst = 1'b0;

    // single requester, data A0..A5 split into a 4-beat and a 2-beat grant
    base[2] = 'hA0; drive_data();
    w0 = w_cnt; req_valid = 4'b0100;
    for (int c = 0; c < 40 && seq[2] < 6; c++) begin
      step();
      if (seq[2] >= 6) req_valid = '0;
    end
    chk("single_done", 64'(seq[2]), 64'(6));
    chk("single_writes", 64'(w_cnt - w0), 64'(6));
    chk("single_last", 64'(last_data), 64'hA5);
    base[2] = 2 << 12;

    // all requesting: 4 beats per grant with one bubble
    do_reset(); w0 = w_cnt; req_valid = 4'b1111;
    repeat (20) step();
    chk("all_writes", 64'(w_cnt - w0), 64'(16));
    chk("all_last_owner", 64'(last_data[15:12]), 64'(3));

    // full stall mid-burst of requester 1
    do_reset(); w0 = w_cnt; req_valid = 4'b0010;
    repeat (3) step();
    chk("stall_pre", 64'(w_cnt - w0), 64'(2));
    fifo_full = 1'b1; w0 = w_cnt;
    repeat (5) step();
    chk("stall_writes", 64'(w_cnt - w0), 64'(0));
    chk("stall_gid", 64'(grant_id), 64'(1));
    fifo_full = 1'b0; w0 = w_cnt;
    repeat (2) step();
    chk("stall_post", 64'(w_cnt - w0), 64'(2));
    chk("stall_release", 64'(grant_active), 64'(0));
    req_valid = '0;

    // early drop by requester 3 hands the pointer to 0
    do_reset(); w0 = w_cnt; req_valid = 4'b1000;
    repeat (2) step();
    chk("drop_first", 64'(last_data[15:12]), 64'(3));
    req_valid = 4'b0001;
    step();
    chk("drop_idle", 64'(grant_active), 64'(0));
    repeat (2) step();
    chk("drop_next", 64'(last_data[15:12]), 64'(0));
    chk("drop_writes", 64'(w_cnt - w0), 64'(2));
    req_valid = '0;

    // asynchronous reset between edges during a burst
    do_reset(); req_valid = 4'b1111;
    repeat (3) step();
    #2 rst = 1'b1;
    #1;
    chk("async_outputs", 64'({req_ready, fifo_wr_en, fifo_data_in, grant_active, grant_id}), 64'(0));
    step();
    rst = 1'b0; w0 = w_cnt; req_valid = 4'b1010;
    repeat (2) step();
    chk("async_regrant", 64'(last_data[15:12]), 64'(1));
    chk("async_writes", 64'(w_cnt - w0), 64'(1));

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(9) < 7);
        base[i]      = (i << 12) | int'($urandom_range(255));
      end
      fifo_full = ($urandom_range(4) == 0);
      drive_data();
      step();
    end
    req_valid = '0; fifo_full = 1'b0;
    step();

`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("stat_random", 64'(stat_grants[i*16 +: 16]), 64'(m_stats[i]));
    do_reset(); req_valid = 4'b0001;
    repeat (4) step();
    req_valid = 4'b0100;
    repeat (6) step();
    req_valid = '0;
    step();
    chk("stat0", 64'(stat_grants[0 +: 16]), 64'(3));
    chk("stat1", 64'(stat_grants[16 +: 16]), 64'(0));
    chk("stat2", 64'(stat_grants[32 +: 16]), 64'(4));
    chk("stat3", 64'(stat_grants[48 +: 16]), 64'(0));
`endif

    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
